// File: rtl/antiprobe_pkg.sv
// Shared types and constants for the anti-probe pad scan path.
// Used by the scan controller, its hit counter and the logging blocks.
package antiprobe_pkg;

  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_GAP_CYCLES    = 8;
  localparam int DEF_LOG_SAMPLES   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT,
    GAP,
    DONE
  } scan_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/antiprobe_hit_counter.sv
// Counts comparator-high samples while enabled; clear has priority.
// Ports: clk, rst_n (sync), clr, en, bit_in -> cnt (CNT_W).
module antiprobe_hit_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && bit_in) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The window length fits CNT_W by construction; a wrap means misuse.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && en && bit_in) begin
      assert (cnt_q != '1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/antiprobe_scan_ctrl.sv
// Pad comparator scan sequencer: settle, count highs, report per pad.
// Ports: start/cfg_* in, cmp_data in, drv_en_n out, res_* stream, busy/scan_done.
module antiprobe_scan_ctrl
  import antiprobe_pkg::*;
#(
  parameter  int NUM_PADS      = 3,
  parameter  int LOG_SAMPLES   = DEF_LOG_SAMPLES,
  parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter  int GAP_CYCLES    = DEF_GAP_CYCLES,
  localparam int CNT_W         = LOG_SAMPLES + 1,
  localparam int PAD_W         = (clog2(NUM_PADS) > 1) ?
                                 clog2(NUM_PADS) : 1
) (
  input  logic                sample_clk,
  input  logic                sample_rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_baseline,
  input  logic [CNT_W-1:0]    cfg_tol,
  input  logic [NUM_PADS-1:0] cmp_data,
  output logic                drv_en_n,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PAD_W-1:0]    res_pad,
  output logic [CNT_W-1:0]    res_count,
  output logic                res_alarm,
  output logic                scan_done
);

  localparam int WIN = 1 << LOG_SAMPLES;
  localparam int TMR_MAX =
    (WIN > SETTLE_CYCLES) ?
      ((WIN > GAP_CYCLES) ? WIN : GAP_CYCLES) :
      ((SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES);
  localparam int TMR_W =
    (clog2(TMR_MAX) > 1) ? clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SET_T  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_T  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] MEAS_T = TMR_W'(WIN - 1);
  localparam logic [PAD_W-1:0] LAST   = PAD_W'(NUM_PADS - 1);

  scan_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [PAD_W-1:0] pad_q, pad_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] tol_q, tol_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] diff;

  antiprobe_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hits (
    .clk    (sample_clk),
    .rst_n  (sample_rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .bit_in (cmp_data[pad_q]),
    .cnt    (cnt)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pad_d   = pad_q;
    base_d  = base_q;
    tol_d   = tol_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = cfg_baseline;
          tol_d   = cfg_tol;
          pad_d   = '0;
          timer_d = SET_T;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          cnt_clr = 1'b1;
          timer_d = MEAS_T;
          state_d = MEASURE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      MEASURE: begin
        cnt_en = 1'b1;
        if (timer_q == '0) begin
          state_d = REPORT;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      REPORT: begin
        if (res_ready) begin
          if (pad_q == LAST) begin
            state_d = DONE;
          end else begin
            pad_d   = pad_q + PAD_W'(1);
            timer_d = GAP_T;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          timer_d = SET_T;
          state_d = SETTLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (!sample_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pad_q   <= '0;
      base_q  <= '0;
      tol_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pad_q   <= pad_d;
      base_q  <= base_d;
      tol_q   <= tol_d;
    end
  end

  // Alarm tracks the registered count, so it is valid with res_valid.
  always_comb begin
    diff = (base_q >= cnt) ? (base_q - cnt) : (cnt - base_q);
  end

  assign drv_en_n  = !((state_q == SETTLE) || (state_q == MEASURE));
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);
  assign scan_done = (state_q == DONE);
  assign res_pad   = pad_q;
  assign res_count = cnt;
  assign res_alarm = (diff > tol_q);

endmodule

// File: tb/tb_antiprobe_scan_ctrl.sv
// Self-checking bench for antiprobe_scan_ctrl.
// Timeline model derived from settle/window/gap arithmetic.
module tb_antiprobe_scan_ctrl;

  localparam int N   = 3;
  localparam int L   = 8;
  localparam int S   = 16;
  localparam int G   = 8;
  localparam int W   = 1 << L;
  localparam int CW  = L + 1;
  localparam int HSZ = 4096;

  logic          sample_clk = 1'b0;
  logic          sample_rst_n;
  logic          start;
  logic [CW-1:0] cfg_baseline;
  logic [CW-1:0] cfg_tol;
  logic [N-1:0]  cmp_data;
  logic          drv_en_n;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_pad;
  logic [CW-1:0] res_count;
  logic          res_alarm;
  logic          scan_done;

  int          total = 0;
  int          bad = 0;
  int unsigned edge_n = 0;
  int          mode = 0;
  logic [N-1:0] hist [0:HSZ-1];

  always #5 sample_clk = ~sample_clk;

  antiprobe_scan_ctrl #(
    .NUM_PADS      (N),
    .LOG_SAMPLES   (L),
    .SETTLE_CYCLES (S),
    .GAP_CYCLES    (G)
  ) dut (
    .sample_clk   (sample_clk),
    .sample_rst_n (sample_rst_n),
    .start        (start),
    .cfg_baseline (cfg_baseline),
    .cfg_tol      (cfg_tol),
    .cmp_data     (cmp_data),
    .drv_en_n     (drv_en_n),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_pad      (res_pad),
    .res_count    (res_count),
    .res_alarm    (res_alarm),
    .scan_done    (scan_done)
  );

  function automatic logic [N-1:0] gen_cmp();
    logic [31:0] e;
    e = edge_n;
    case (mode)
      0: return 3'b111;
      1: return {1'b0, e[0], 1'b0};
      2: return 3'($urandom);
      default: return 3'b000;
    endcase
  endfunction

  // Inputs set before the call are sampled by the next edge; the
  // comparator value seen by edge k is logged in hist[k].
  task automatic tick();
    cmp_data = gen_cmp();
    hist[(edge_n + 1) % HSZ] = cmp_data;
    @(posedge sample_clk);
    #1;
    edge_n++;
  endtask

  function automatic int exp_count(input int p, input int unsigned ms);
    int s;
    s = 0;
    for (int i = 0; i < W; i++) s += int'(hist[(ms + i) % HSZ][p]);
    return s;
  endfunction

  task automatic do_scan(input int base, input int tol,
                         input int stall_pad, input int stall_len,
                         input bit inject, input int rst_pad);
    int unsigned e0, sb, ms, h;
    int ec, diff, guard, dones;
    bit ea, drv_bad, idle_bad;
    logic [1:0] hp;
    logic [CW-1:0] hc;
    cfg_baseline = CW'(base);
    cfg_tol = CW'(tol);
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = edge_n;
    total++;
    if (busy !== 1'b1 || drv_en_n !== 1'b0) begin
      bad++;
      $display("FAIL start_ack busy=%b drv_en_n=%b want 1/0", busy, drv_en_n);
    end
    sb = e0;
    ms = e0 + S + 1;
    for (int p = 0; p < N; p++) begin
      drv_bad = 1'b0;
      guard = 0;
      while (res_valid !== 1'b1 && guard < S + G + W + 20) begin
        if (inject && p == 1 && edge_n == ms + 100) begin
          start = 1'b1;
          cfg_baseline = ~cfg_baseline;
          cfg_tol = ~cfg_tol;
        end
        if (p == rst_pad && edge_n == ms + 50) begin
          sample_rst_n = 1'b0;
          tick();
          sample_rst_n = 1'b1;
          total++;
          if (drv_en_n !== 1'b1 || busy !== 1'b0 ||
              res_valid !== 1'b0 || res_pad !== 2'd0 ||
              res_count !== '0 || res_alarm !== 1'b0 ||
              scan_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset drv=%b busy=%b vld=%b pad=%0d cnt=%0d alm=%b done=%b want 1,0,0,0,0,0,0",
                     drv_en_n, busy, res_valid, res_pad, res_count,
                     res_alarm, scan_done);
          end
          return;
        end
        tick();
        start = 1'b0;
        guard++;
        if (drv_en_n !== ((edge_n >= sb && edge_n <= ms + W - 2) ?
                          1'b0 : 1'b1)) drv_bad = 1'b1;
      end
      total++;
      if (res_valid !== 1'b1) begin
        bad++;
        $display("FAIL timeout pad%0d res_valid=%b want 1", p, res_valid);
        return;
      end
      total++;
      if (edge_n != ms + W - 1) begin
        bad++;
        $display("FAIL latency pad%0d edge=%0d want %0d",
                 p, edge_n, ms + W - 1);
      end
      total++;
      if (drv_bad) begin
        bad++;
        $display("FAIL drv_window pad%0d got wrong drv_en_n want low only in settle/measure", p);
      end
      ec = exp_count(p, ms);
      diff = (ec > base) ? ec - base : base - ec;
      ea = (diff > tol);
      total++;
      if (res_pad !== 2'(p)) begin
        bad++;
        $display("FAIL res_pad got=%0d want=%0d", res_pad, p);
      end
      total++;
      if (res_count !== CW'(ec)) begin
        bad++;
        $display("FAIL res_count pad%0d got=%0d want=%0d", p, res_count, ec);
      end
      total++;
      if (res_alarm !== ea) begin
        bad++;
        $display("FAIL res_alarm pad%0d got=%b want=%b", p, res_alarm, ea);
      end
      if (p == stall_pad) begin
        res_ready = 1'b0;
        hp = res_pad;
        hc = res_count;
        drv_bad = 1'b0;
        repeat (stall_len) begin
          tick();
          if (res_valid !== 1'b1 || res_pad !== hp ||
              res_count !== hc || drv_en_n !== 1'b1) drv_bad = 1'b1;
        end
        total++;
        if (drv_bad) begin
          bad++;
          $display("FAIL stall_hold vld=%b pad=%0d cnt=%0d drv=%b want 1,%0d,%0d,1",
                   res_valid, res_pad, res_count, drv_en_n, hp, hc);
        end
        res_ready = 1'b1;
      end
      tick();
      h = edge_n;
      sb = h + G;
      ms = sb + S + 1;
    end
    total++;
    if (scan_done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse scan_done=%b busy=%b want 1/1", scan_done, busy);
    end
    dones = 1;
    start = inject;
    tick();
    start = 1'b0;
    total++;
    if (scan_done !== 1'b0 || busy !== 1'b0 || drv_en_n !== 1'b1) begin
      bad++;
      $display("FAIL idle_after done=%b busy=%b drv=%b want 0,0,1",
               scan_done, busy, drv_en_n);
    end
    idle_bad = 1'b0;
    repeat (20) begin
      tick();
      if (scan_done === 1'b1) dones++;
      if (busy !== 1'b0) idle_bad = 1'b1;
    end
    total++;
    if (dones != 1 || idle_bad) begin
      bad++;
      $display("FAIL single_done dones=%0d busy_seen=%b want 1/0", dones, idle_bad);
    end
  endtask

  task automatic test_reset();
    sample_rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (drv_en_n !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
        res_pad !== 2'd0 || res_count !== '0 ||
        res_alarm !== 1'b0 || scan_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals drv=%b busy=%b vld=%b pad=%0d cnt=%0d alm=%b done=%b want 1,0,0,0,0,0,0",
               drv_en_n, busy, res_valid, res_pad, res_count,
               res_alarm, scan_done);
    end
    sample_rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (drv_en_n !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_vals drv=%b busy=%b vld=%b want 1,0,0",
               drv_en_n, busy, res_valid);
    end
  endtask

  task automatic test_all_high();
    mode = 0;
    do_scan(256, 0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_toggle();
    mode = 1;
    do_scan(128, 4, -1, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    mode = 2;
    do_scan(int'($urandom_range(100, 156)), int'($urandom_range(0, 20)),
            0, 50, 1'b0, -1);
  endtask

  task automatic test_ignore_start();
    mode = 2;
    do_scan(int'($urandom_range(0, 256)), int'($urandom_range(0, 30)),
            -1, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    mode = 0;
    do_scan(256, 0, -1, 0, 1'b0, 1);
    repeat (5) tick();
    mode = 2;
    do_scan(128, 10, -1, 0, 1'b0, -1);
  endtask

  task automatic test_boundary();
    mode = 0;
    do_scan(0, 255, -1, 0, 1'b0, -1);
    do_scan(0, 256, -1, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      mode = 2;
      do_scan(int'($urandom_range(0, 256)), int'($urandom_range(0, 16)),
              int'($urandom_range(0, N - 1)),
              int'($urandom_range(1, 9)), 1'b0, -1);
    end
  endtask

  initial begin
    sample_rst_n = 1'b0;
    start = 1'b0;
    cfg_baseline = '0;
    cfg_tol = '0;
    cmp_data = '0;
    res_ready = 1'b1;
    test_reset();
    test_all_high();
    test_toggle();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
